latch_bank_write_sched: RTL and testbench
=========================================

Name: latch_bank_write_sched

Overview:
- Sequences writes into a bank of DEPTH gate-level clocked D-latch words, each WIDTH bits, with a shared data bus and a per-word gate enable.
- Arbitrates round-robin between NREQ requesters.
- Enforces setup, gate-high and hold windows in clk cycles so the latches' gate delays are always respected.
- Also sequences a bank-wide clear through the latches' reset input.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, latch word width
DEPTH, 4, number of latch words; AW = max(1, clog2(DEPTH))
SETUP_CYC, 1, cycles data is stable before gate rises (>=1)
EN_CYC, 2, cycles gate or latch reset is held high (>=1)
HOLD_CYC, 1, cycles data is held after gate falls (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
req  in  NREQ  per-requester write request, level
wdata  in  NREQ*WIDTH  requester i data in slice [i*WIDTH +: WIDTH]
waddr  in  NREQ*AW  requester i word address in slice [i*AW +: AW]
clr_req  in  1  single-cycle pulse requesting a bank clear
gnt  out  NREQ  one-hot grant, held for the whole transaction
done  out  NREQ  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse with done when the address is >= DEPTH
latch_d  out  WIDTH  shared data bus to the latch bank
latch_en  out  DEPTH  one-hot gate enables (clk input of each latch word)
latch_rst  out  1  bank-wide latch reset
clr_done  out  1  one-cycle pulse at the end of a clear

Behaviour:
Reset (clk edge with rst=1):
- All outputs go to 0.
- State goes to IDLE, round-robin pointer to 0, clear-pending flag to 0.
- rst mid-transaction drops latch_en and latch_rst on that same edge. The target word content is then undefined, and no done or clr_done is issued.

Clear-pending flag:
- Set by clr_req in any state; cleared on entry to CLR.
- A second clr_req while the flag is already set is absorbed (only one clear is performed).

State machine (all outputs registered):
- IDLE:
  - If the clear-pending flag (or a same-cycle clr_req) is set, go to CLR. Clear has priority over writes.
  - Otherwise, if any req is high, choose the winner: the first req at or above the pointer, wrapping from NREQ-1 to 0.
  - Capture the winner's wdata and waddr into internal registers. Set gnt[winner] and go to SETUP.
- SETUP, SETUP_CYC cycles: latch_d = captured data, latch_en = 0.
- ENABLE, EN_CYC cycles: latch_en[addr] = 1 when addr < DEPTH, otherwise all zero. latch_d is unchanged.
- HOLD, HOLD_CYC cycles: latch_en = 0, latch_d still held.
- DONE, 1 cycle:
  - done[winner] = 1 and gnt drops to 0.
  - err = 1 if addr >= DEPTH.
  - pointer = winner+1 mod NREQ. Next state IDLE.
  - latch_d keeps its value until the next capture.
- CLR: latch_rst = 1 for EN_CYC cycles, then 0 for HOLD_CYC cycles, then a clr_done pulse on the return to IDLE.

Latency:
- req sampled in IDLE at cycle 0 → gnt high from cycle 1 → done at cycle 1+SETUP_CYC+EN_CYC+HOLD_CYC (5 with defaults).
- The next grant comes no earlier than the cycle after DONE, so writes are never back-to-back.

Other rules:
- latch_en and latch_rst are never high in the same cycle. At most one latch_en bit is high.
- A req dropped mid-transaction is ignored; the write completes and done is still pulsed.
- A requester holding req high after its done is re-eligible, but only after the others, because the pointer has moved past it.
- wdata and waddr are sampled only in IDLE; changes during a transaction have no effect.
- Cycle counters are sized for max(SETUP_CYC, EN_CYC, HOLD_CYC).

Test Plan:
- Single write, defaults:
  - Stimulus: req=0001, wdata0=0xA5, waddr0=2 at cycle 0.
  - Response: gnt=0001 during cycles 1-4, latch_d=0xA5 during cycles 1-5, latch_en=0100 during cycles 2-3 only, done=0001 and gnt=0 at cycle 5.
- Round robin:
  - Stimulus: req=1111 held continuously.
  - Response: grants in order 0,1,2,3,0. Each done is spaced exactly 6 cycles apart.
  - Variant: req=1010 with pointer=2 → requester 3 is granted before 1.
- Clear priority:
  - Stimulus: clr_req pulse mid-write with req=0010 pending.
  - Response: the current write completes; the next state is CLR; latch_rst is high 2 cycles, then low 1 cycle; clr_done pulses; only then is requester 1 granted.
- Out-of-range address:
  - Stimulus: DEPTH=3, waddr=3.
  - Response: latch_en stays 000 throughout; done and err pulse together.
- Reset mid-ENABLE:
  - Stimulus: rst=1 during the ENABLE state.
  - Response: on the next edge latch_en=0, gnt=0, no done is issued, pointer=0.
- Input change mid-transaction:
  - Stimulus: wdata and waddr changed, and req dropped, during SETUP.
  - Response: latch_d and the enabled word still reflect the IDLE-sampled values; done is still pulsed.

Source files
------------

// File: rtl/latch_bank_write_sched.sv
// Write sequencer for a bank of gate-clocked D-latch words.
// Round-robin arbitration between requesters, timed setup/gate/hold windows
// around each latch gate pulse, and a bank-wide clear through the latch reset.
module latch_bank_write_sched #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [NREQ*AW-1:0]    waddr,
  input  logic                  clr_req,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [WIDTH-1:0]      latch_d,
  output logic [DEPTH-1:0]      latch_en,
  output logic                  latch_rst,
  output logic                  clr_done
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (SETUP_CYC > EN_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_DONE, S_CLR_EN, S_CLR_HOLD
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [PW-1:0]     win_reg, win_next;
  logic [AW-1:0]     addr_reg, addr_next;
  logic              pend_reg, pend_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   done_reg, done_next;
  logic              err_reg, err_next;
  logic [WIDTH-1:0]  latch_d_reg, latch_d_next;
  logic [DEPTH-1:0]  latch_en_reg, latch_en_next;
  logic              latch_rst_reg, latch_rst_next;
  logic              clr_done_reg, clr_done_next;

  logic [WIDTH-1:0]  wdata_arr [NREQ];
  logic [AW-1:0]     waddr_arr [NREQ];
  logic [DEPTH-1:0]  addr_dec;
  logic              addr_ok;
  logic              found;
  logic [PW-1:0]     win_sel;

  // Per-requester views of the packed data/address buses.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    assign waddr_arr[gi] = waddr[gi*AW +: AW];
  end

  // One-hot decode of the captured address; all-zero when out of range.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
    assign addr_dec[gi] = (int'(addr_reg) == gi);
  end
  assign addr_ok = (int'(addr_reg) < DEPTH);

  // Round-robin pick: first active request at or above the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    win_sel = ptr_reg;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr_reg) + i) % NREQ]) begin
        found   = 1'b1;
        win_sel = PW'((int'(ptr_reg) + i) % NREQ);
      end
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ptr_next       = ptr_reg;
    win_next       = win_reg;
    addr_next      = addr_reg;
    pend_next      = pend_reg | clr_req;
    gnt_next       = gnt_reg;
    done_next      = '0;
    err_next       = 1'b0;
    latch_d_next   = latch_d_reg;
    latch_en_next  = '0;
    latch_rst_next = 1'b0;
    clr_done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pend_reg || clr_req) begin
          state_next     = S_CLR_EN;
          cnt_next       = '0;
          pend_next      = 1'b0;
          latch_rst_next = 1'b1;
        end else if (found) begin
          state_next        = S_SETUP;
          cnt_next          = '0;
          win_next          = win_sel;
          addr_next         = waddr_arr[win_sel];
          latch_d_next      = wdata_arr[win_sel];
          gnt_next          = '0;
          gnt_next[win_sel] = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_reg == CW'(SETUP_CYC - 1)) begin
          state_next    = S_ENABLE;
          cnt_next      = '0;
          latch_en_next = addr_dec;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_ENABLE: begin
        if (cnt_reg == CW'(EN_CYC - 1)) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next      = cnt_reg + 1'b1;
          latch_en_next = latch_en_reg;
        end
      end
      S_HOLD: begin
        if (cnt_reg == CW'(HOLD_CYC - 1)) begin
          state_next = S_DONE;
          cnt_next   = '0;
          done_next  = gnt_reg;
          gnt_next   = '0;
          err_next   = !addr_ok;
          ptr_next   = PW'((int'(win_reg) + 1) % NREQ);
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_CLR_EN: begin
        if (cnt_reg == CW'(EN_CYC - 1)) begin
          state_next = S_CLR_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next       = cnt_reg + 1'b1;
          latch_rst_next = 1'b1;
        end
      end
      S_CLR_HOLD: begin
        if (cnt_reg == CW'(HOLD_CYC - 1)) begin
          state_next    = S_IDLE;
          cnt_next      = '0;
          clr_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers; reset drops gate/reset strobes immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      win_reg       <= '0;
      addr_reg      <= '0;
      pend_reg      <= 1'b0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= 1'b0;
      latch_d_reg   <= '0;
      latch_en_reg  <= '0;
      latch_rst_reg <= 1'b0;
      clr_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      win_reg       <= win_next;
      addr_reg      <= addr_next;
      pend_reg      <= pend_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      latch_d_reg   <= latch_d_next;
      latch_en_reg  <= latch_en_next;
      latch_rst_reg <= latch_rst_next;
      clr_done_reg  <= clr_done_next;
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign latch_d   = latch_d_reg;
  assign latch_en  = latch_en_reg;
  assign latch_rst = latch_rst_reg;
  assign clr_done  = clr_done_reg;

endmodule

// File: tb/tb_latch_bank_write_sched.sv
// Bench for latch_bank_write_sched: two instances (DEPTH=4 and DEPTH=3) share
// stimulus; a transaction-timeline model predicts every output each cycle.
module tb_latch_bank_write_sched;

  localparam int N = 4;
  localparam int W = 8;
  localparam int A = 2;
  localparam int S = 1;
  localparam int E = 2;
  localparam int H = 1;
  localparam int L = S + E + H;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N*A-1:0] waddr;
  logic           clr_req;

  logic [N-1:0] gnt, done, gnt3, done3;
  logic         err, err3, latch_rst, latch_rst3, clr_done, clr_done3;
  logic [W-1:0] latch_d, latch_d3;
  logic [3:0]   latch_en;
  logic [2:0]   latch_en3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  latch_bank_write_sched dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr),
    .clr_req(clr_req), .gnt(gnt), .done(done), .err(err), .latch_d(latch_d),
    .latch_en(latch_en), .latch_rst(latch_rst), .clr_done(clr_done)
  );

  latch_bank_write_sched #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr),
    .clr_req(clr_req), .gnt(gnt3), .done(done3), .err(err3), .latch_d(latch_d3),
    .latch_en(latch_en3), .latch_rst(latch_rst3), .clr_done(clr_done3)
  );

  // Model: mode 0 idle, 1 write, 2 clear; m_t counts cycles since the start edge.
  int         m_mode = 0;
  int         m_t = 0;
  int         m_win = 0;
  int         m_ptr = 0;
  int         m_addr = 0;
  bit         m_pend = 0;
  bit         m_clrdone = 0;
  logic [W-1:0] m_d = '0;

  task automatic model_edge();
    bit cd;
    cd = 0;
    if (rst) begin
      m_mode = 0; m_t = 0; m_ptr = 0; m_pend = 0; m_d = '0; m_clrdone = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (m_pend || clr_req) begin
          m_mode = 2; m_t = 1; m_pend = 0;
        end else begin
          for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req[k]) begin
              m_mode = 1; m_t = 1; m_win = k;
              m_addr = int'(waddr[k*A +: A]);
              m_d = wdata[k*W +: W];
              break;
            end
          end
        end
      end
      1: begin
        m_pend = m_pend | clr_req;
        if (m_t == L + 1) m_mode = 0;
        else begin
          m_t++;
          if (m_t == L + 1) m_ptr = (m_win + 1) % N;
        end
      end
      default: begin
        m_pend = m_pend | clr_req;
        if (m_t == E + H) begin m_mode = 0; cd = 1; end
        else m_t++;
      end
    endcase
    m_clrdone = cd;
  endtask

  function automatic logic [31:0] e_gnt();
    return (m_mode == 1 && m_t <= L) ? (32'd1 << m_win) : 32'd0;
  endfunction
  function automatic logic [31:0] e_done();
    return (m_mode == 1 && m_t == L + 1) ? (32'd1 << m_win) : 32'd0;
  endfunction
  function automatic logic [31:0] e_err(input int depth);
    return (m_mode == 1 && m_t == L + 1 && m_addr >= depth) ? 32'd1 : 32'd0;
  endfunction
  function automatic logic [31:0] e_en(input int depth);
    return (m_mode == 1 && m_t > S && m_t <= S + E && m_addr < depth) ? (32'd1 << m_addr) : 32'd0;
  endfunction
  function automatic logic [31:0] e_rst();
    return (m_mode == 2 && m_t <= E) ? 32'd1 : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), e_gnt());
    chk("done", 32'(done), e_done());
    chk("err", 32'(err), e_err(4));
    chk("latch_d", 32'(latch_d), 32'(m_d));
    chk("latch_en", 32'(latch_en), e_en(4));
    chk("latch_rst", 32'(latch_rst), e_rst());
    chk("clr_done", 32'(clr_done), 32'(m_clrdone));
    chk("gnt3", 32'(gnt3), e_gnt());
    chk("done3", 32'(done3), e_done());
    chk("err3", 32'(err3), e_err(3));
    chk("latch_d3", 32'(latch_d3), 32'(m_d));
    chk("latch_en3", 32'(latch_en3), e_en(3));
    chk("latch_rst3", 32'(latch_rst3), e_rst());
    chk("clr_done3", 32'(clr_done3), 32'(m_clrdone));
    chk("en_rst_excl", 32'((|latch_en) & latch_rst), 32'd0);
    chk("en_onehot0", 32'($countones(latch_en) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (done == 0 && n < maxc) begin
      step();
      n++;
    end
    if (done == 0) begin
      checks++;
      errors++;
      $error("FAIL wait_done timeout observed=none expected=done within %0d", maxc);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int n;
    int g_order [5];
    int d_cyc [5];
    int gn, dn, rst_cnt, cd_c, g1_c;
    logic [N-1:0] prev;

    rst = 1; req = '0; wdata = '0; waddr = '0; clr_req = 0;
    step(); step();
    rst = 0;
    step();
    $display("reset: outputs checked idle");

    // Single write: requester 0, 0xA5 to word 2.
    wdata[7:0] = 8'hA5; waddr[1:0] = 2'd2; req = 4'b0001;
    step();
    req = '0;
    wait_done(20, n);
    chk("single_latency", 32'(1 + n), 32'd5);
    $display("single write: done at cycle %0d", 1 + n);
    step();

    // Round robin with all requesting, from a fresh pointer.
    rst = 1; step(); rst = 0;
    req = 4'b1111;
    gn = 0; dn = 0; prev = '0;
    for (int c = 0; c < 60 && dn < 5; c++) begin
      step();
      if (gnt != 0 && prev == 0 && gn < 5) begin g_order[gn] = oh_idx(gnt); gn++; end
      if (done != 0 && dn < 5) begin d_cyc[dn] = c; dn++; end
      prev = gnt;
    end
    req = '0;
    chk("rr_count", 32'(dn), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", 32'(g_order[k]), 32'(k % 4));
      if (k > 0) chk("rr_spacing", 32'(d_cyc[k] - d_cyc[k-1]), 32'd6);
      $display("round robin: grant %0d to requester %0d", k, g_order[k]);
    end

    // Move pointer to 2, then requesters 1 and 3 compete: 3 must win.
    step(); step();
    req = 4'b0010; step(); req = '0;
    wait_done(20, n); step();
    req = 4'b1010; step();
    chk("rr_variant", 32'(gnt), 32'b1000);
    $display("round robin variant: gnt=%b", gnt);
    req = '0;
    wait_done(20, n); step();

    // Clear arrives mid-write with requester 1 waiting.
    req = 4'b0001; step();
    req = 4'b0010; clr_req = 1; step(); clr_req = 0;
    rst_cnt = 0; cd_c = -100; g1_c = -1;
    for (int c = 0; c < 40 && g1_c < 0; c++) begin
      step();
      if (latch_rst) rst_cnt++;
      if (clr_done) cd_c = c;
      if (gnt == 4'b0010) g1_c = c;
    end
    req = '0;
    chk("clr_rst_len", 32'(rst_cnt), 32'd2);
    chk("clr_then_gnt", 32'(g1_c - cd_c), 32'd1);
    $display("clear: latch_rst cycles=%0d, grant to 1 %0d cycles after clr_done", rst_cnt, g1_c - cd_c);
    wait_done(20, n); step();

    // Out-of-range address on the 3-word instance.
    wdata[7:0] = 8'h5A; waddr[1:0] = 2'd3; req = 4'b0001; step(); req = '0;
    wait_done(20, n);
    chk("oor_err3", 32'(err3), 32'd1);
    chk("oor_err4", 32'(err), 32'd0);
    $display("out-of-range: err3=%b err=%b", err3, err);
    step();

    // Reset in the middle of the gate pulse.
    waddr[5:4] = 2'd1; wdata[23:16] = 8'h77; req = 4'b0100;
    step(); req = '0; step();
    chk("pre_rst_en", 32'(latch_en), 32'b0010);
    rst = 1; step(); rst = 0;
    chk("rst_en", 32'(latch_en), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    for (int c = 0; c < 6; c++) step();
    req = 4'b1111; step();
    chk("rst_ptr", 32'(gnt), 32'b0001);
    $display("reset mid-enable: first grant after reset gnt=%b", gnt);
    req = '0;
    wait_done(20, n); step();

    // Inputs changed and req dropped during SETUP.
    wdata[7:0] = 8'h3C; waddr[1:0] = 2'd1; req = 4'b0001; step();
    wdata[7:0] = 8'hFF; waddr[1:0] = 2'd3; req = '0; step();
    chk("ic_latch_d", 32'(latch_d), 32'h3C);
    chk("ic_latch_en", 32'(latch_en), 32'b0010);
    wait_done(20, n);
    chk("ic_done", 32'(done), 32'b0001);
    $display("input change: latch_d=%h done=%b", latch_d, done);
    step();

    // Randomized traffic with occasional clears and resets.
    for (int c = 0; c < 400; c++) begin
      req     = 4'($urandom_range(0, 15));
      wdata   = $urandom;
      waddr   = 8'($urandom);
      clr_req = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; req = '0; clr_req = 0;
    $display("random: 400 cycles applied");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
